// File: rtl/stt8_entity_pkg.sv
// Shared definitions for entity descriptors feeding the frame buffer controller.
package stt8_entity_pkg;

  // Descriptor field widths
  localparam int unsigned ID_W     = 4;
  localparam int unsigned ORIENT_W = 2;
  localparam int unsigned LOC_W    = 8;
  localparam int unsigned ENTITY_W = ID_W + ORIENT_W + LOC_W;

  // Orientation encoding
  localparam logic [ORIENT_W-1:0] ORIENT_UP    = 2'b00;
  localparam logic [ORIENT_W-1:0] ORIENT_RIGHT = 2'b01;
  localparam logic [ORIENT_W-1:0] ORIENT_DOWN  = 2'b10;
  localparam logic [ORIENT_W-1:0] ORIENT_LEFT  = 2'b11;

  // First line of vertical blanking
  localparam logic [9:0] VBLANK_LINE = 10'd480;

  // ID reserved for an unused frame buffer channel
  localparam logic [ID_W-1:0] UNUSED_ID = 4'hF;

  // Packed layout of one entity channel
  typedef struct packed {
    logic [ID_W-1:0]     id;
    logic [ORIENT_W-1:0] orient;
    logic [3:0]          x;
    logic [3:0]          y;
  } entity_t;

  // Resolve simultaneous held directions: up > right > down > left
  function automatic logic [ORIENT_W-1:0] pick_orient(
    input logic up,
    input logic right,
    input logic down,
    input logic left
  );
    logic [ORIENT_W-1:0] o;
    o = ORIENT_LEFT;
    if (up)         o = ORIENT_UP;
    else if (right) o = ORIENT_RIGHT;
    else if (down)  o = ORIENT_DOWN;
    else if (left)  o = ORIENT_LEFT;
    return o;
  endfunction

endpackage

// File: rtl/button_sync_debounce.sv
// Two-flop synchroniser for one raw button plus a history bit sampled on the
// frame tick; 'held' is true when the button was high on this tick and the last.
module button_sync_debounce
  import stt8_entity_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic tick,
  output logic held
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic hist_q,  hist_d;

  // Next-state: shift the synchroniser every cycle, history only on a tick
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    hist_d  = hist_q;
    if (tick) begin
      hist_d = sync2_q;
    end
  end

  // Synchroniser and history registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  // Current synchronised sample ANDed with the previous tick's sample
  always_comb begin
    held = sync2_q & hist_q;
  end

endmodule

// File: rtl/player_entity_controller.sv
// Converts four player buttons into a 14-bit entity descriptor that moves at
// most one tile per MOVE_PERIOD frames and updates only at the start of vblank.
module player_entity_controller
  import stt8_entity_pkg::*;
#(
  parameter logic [3:0]  ENTITY_ID   = 4'h1,
  parameter logic [7:0]  START_TILE  = 8'h65,
  parameter int unsigned MOVE_PERIOD = 4,
  parameter int unsigned GRID_ROWS   = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_up,
  input  logic                btn_right,
  input  logic                btn_down,
  input  logic                btn_left,
  input  logic [9:0]          counter_H,
  input  logic [9:0]          counter_V,
  output logic [ENTITY_W-1:0] entity,
  output logic                moving
);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_COOLDOWN = 1'b1;

  localparam logic [3:0] COOL_RELOAD = 4'(MOVE_PERIOD - 1);
  localparam logic [3:0] MAX_X       = 4'd15;
  localparam logic [3:0] MAX_Y       = 4'(GRID_ROWS - 1);
  localparam logic [0:0] ST_AFTER_MOVE = (MOVE_PERIOD == 1) ? ST_IDLE : ST_COOLDOWN;

  logic       tick;
  logic       held_up, held_right, held_down, held_left;
  logic       any_held;
  logic [1:0] dir;
  logic [3:0] x_move, y_move;

  logic [0:0] state_q,  state_d;
  logic [3:0] cool_q,   cool_d;
  logic [1:0] orient_q, orient_d;
  logic [3:0] x_q,      x_d;
  logic [3:0] y_q,      y_d;
  logic       moving_q, moving_d;

  entity_t    ent;

  // Single-cycle pulse on the first pixel of the first vblank line
  always_comb begin
    tick = (counter_V == VBLANK_LINE) && (counter_H == '0);
  end

  button_sync_debounce u_sync_up (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_up),
    .tick    (tick),
    .held    (held_up)
  );

  button_sync_debounce u_sync_right (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_right),
    .tick    (tick),
    .held    (held_right)
  );

  button_sync_debounce u_sync_down (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_down),
    .tick    (tick),
    .held    (held_down)
  );

  button_sync_debounce u_sync_left (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_left),
    .tick    (tick),
    .held    (held_left)
  );

  // Winning direction and the clamped location it would lead to
  always_comb begin
    any_held = held_up | held_right | held_down | held_left;
    dir      = pick_orient(held_up, held_right, held_down, held_left);
    x_move   = x_q;
    y_move   = y_q;
    case (dir)
      ORIENT_UP:    if (y_q != 4'd0)  y_move = y_q - 4'd1;
      ORIENT_RIGHT: if (x_q <  MAX_X) x_move = x_q + 4'd1;
      ORIENT_DOWN:  if (y_q <  MAX_Y) y_move = y_q + 4'd1;
      default:      if (x_q != 4'd0)  x_move = x_q - 4'd1;
    endcase
  end

  // Movement FSM; a blocked move still turns the entity and restarts the cooldown
  always_comb begin
    state_d  = state_q;
    cool_d   = cool_q;
    orient_d = orient_q;
    x_d      = x_q;
    y_d      = y_q;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (any_held) begin
            orient_d = dir;
            x_d      = x_move;
            y_d      = y_move;
            cool_d   = COOL_RELOAD;
            state_d  = ST_AFTER_MOVE;
          end
        end
        default: begin
          if (cool_q != 4'd0) begin
            cool_d = cool_q - 4'd1;
          end else if (any_held) begin
            orient_d = dir;
            x_d      = x_move;
            y_d      = y_move;
            cool_d   = COOL_RELOAD;
            state_d  = ST_AFTER_MOVE;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      endcase
    end
    moving_d = (state_d == ST_COOLDOWN);
  end

  // State, cooldown and descriptor registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cool_q   <= '0;
      orient_q <= ORIENT_UP;
      x_q      <= START_TILE[7:4];
      y_q      <= START_TILE[3:0];
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cool_q   <= cool_d;
      orient_q <= orient_d;
      x_q      <= x_d;
      y_q      <= y_d;
      moving_q <= moving_d;
    end
  end

  // Pack registered fields into the descriptor
  always_comb begin
    ent.id     = ENTITY_ID;
    ent.orient = orient_q;
    ent.x      = x_q;
    ent.y      = y_q;
    entity     = ent;
    moving     = moving_q;
  end

endmodule

// File: tb/tb_player_entity_controller.sv
// Self-checking bench: frames are compressed to a few cycles with one vblank
// tick each; a frame-level reference model predicts descriptor and moving.
module tb_player_entity_controller;

  localparam int MP   = 4;
  localparam int ROWS = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_up, btn_right, btn_down, btn_left;
  logic [9:0]  counter_H, counter_V;
  logic [13:0] entity;
  logic        moving;

  int ncmp  = 0;
  int nfail = 0;

  // Reference model state (frame granularity)
  int         m_x, m_y, m_or, m_cool;
  bit         m_cd;
  logic [3:0] m_prev;

  player_entity_controller #(
    .ENTITY_ID   (4'h1),
    .START_TILE  (8'h65),
    .MOVE_PERIOD (MP),
    .GRID_ROWS   (ROWS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_up    (btn_up),
    .btn_right (btn_right),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .counter_H (counter_H),
    .counter_V (counter_V),
    .entity    (entity),
    .moving    (moving)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", ncmp);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] exp_entity();
    return {4'h1, m_or[1:0], m_x[3:0], m_y[3:0]};
  endfunction

  task automatic model_reset();
    m_x = 6; m_y = 5; m_or = 0; m_cool = 0; m_cd = 0; m_prev = 4'b0000;
  endtask

  task automatic model_move(input logic [3:0] h);
    int d;
    if (h[0])      d = 0;
    else if (h[1]) d = 1;
    else if (h[2]) d = 2;
    else           d = 3;
    m_or = d;
    case (d)
      0: if (m_y > 0)        m_y = m_y - 1;
      1: if (m_x < 15)       m_x = m_x + 1;
      2: if (m_y < ROWS - 1) m_y = m_y + 1;
      default: if (m_x > 0)  m_x = m_x - 1;
    endcase
    m_cool = MP - 1;
  endtask

  // One vblank tick: bit0 up, bit1 right, bit2 down, bit3 left
  task automatic model_tick();
    logic [3:0] cur, h;
    cur = {btn_left, btn_down, btn_right, btn_up};
    h = cur & m_prev;
    m_prev = cur;
    if (!m_cd) begin
      if (h != 0) begin
        model_move(h);
        m_cd = (MP > 1);
      end
    end else if (m_cool > 0) begin
      m_cool = m_cool - 1;
    end else if (h != 0) begin
      model_move(h);
    end else begin
      m_cd = 0;
    end
  endtask

  task automatic drive_idle_counters(input int i);
    case (i)
      0: begin counter_V = 10'd480; counter_H = 10'd1; end
      1: begin counter_V = 10'd479; counter_H = 10'd0; end
      7: begin counter_V = 10'd481; counter_H = 10'd0; end
      default: begin
        counter_V = 10'($urandom_range(0, 524));
        counter_H = 10'($urandom_range(1, 799));
      end
    endcase
  endtask

  // Eight non-tick cycles, the tick cycle, then one cycle to observe the update
  task automatic frame(input bit glitch);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_idle_counters(i);
      if (glitch && (i == 1)) btn_right = ~btn_right;
      if (glitch && (i == 2)) btn_right = ~btn_right;
      chk("hold_entity", entity, exp_entity());
      chk("hold_moving", {13'd0, moving}, {13'd0, m_cd});
    end
    @(negedge clk);
    counter_V = 10'd480;
    counter_H = 10'd0;
    chk("pre_tick_entity", entity, exp_entity());
    model_tick();
    @(negedge clk);
    drive_idle_counters(3);
    chk("post_tick_entity", entity, exp_entity());
    chk("post_tick_moving", {13'd0, moving}, {13'd0, m_cd});
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) frame(1'b0);
  endtask

  // Mid-frame asynchronous reset, checked before any clock edge
  task automatic do_reset();
    @(negedge clk);
    drive_idle_counters(4);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_entity", entity, 14'h0465);
    chk("async_reset_moving", {13'd0, moving}, 14'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    btn_up = 0; btn_right = 0; btn_down = 0; btn_left = 0;
    counter_H = '0; counter_V = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_entity", entity, 14'h0465);
    chk("reset_moving", {13'd0, moving}, 14'd0);
    reset = 1'b0;

    // Single right press
    btn_right = 1;
    frames(2);
    chk("right_2nd_tick", entity, 14'h0575);
    chk("right_moving", {13'd0, moving}, 14'd1);
    btn_right = 0;
    frames(6);
    chk("right_back_idle", {13'd0, moving}, 14'd0);
    do_reset();

    // Held up: moves on ticks 2, 6, 10
    btn_up = 1;
    for (int f = 1; f <= 10; f++) begin
      frame(1'b0);
      if (f == 2)  chk("up_tick2",  entity, 14'h0464);
      if (f == 6)  chk("up_tick6",  entity, 14'h0463);
      if (f == 10) chk("up_tick10", entity, 14'h0462);
    end
    btn_up = 0;
    do_reset();

    // Clamp at bottom then left edge
    btn_down = 1;
    frames(28);
    chk("clamp_down", entity, 14'h066B);
    chk("clamp_down_moving", {13'd0, moving}, 14'd1);
    btn_down = 0;
    btn_left = 1;
    frames(32);
    chk("clamp_left", entity, 14'h070B);
    chk("clamp_left_moving", {13'd0, moving}, 14'd1);
    btn_left = 0;
    do_reset();

    // Opposite directions: up wins
    btn_up = 1; btn_down = 1;
    frames(2);
    chk("prio_up_down", entity, 14'h0464);
    btn_up = 0; btn_down = 0;
    frames(6);
    do_reset();

    // One-tick pulse does not move
    btn_right = 1;
    frames(1);
    btn_right = 0;
    frames(3);
    chk("pulse_no_move", entity, 14'h0465);
    chk("pulse_no_moving", {13'd0, moving}, 14'd0);

    // Toggles between ticks are ignored
    for (int k = 0; k < 4; k++) frame(1'b1);
    chk("glitch_no_move", entity, 14'h0465);

    // Reset during cooldown (cooldown = 2 after the third tick)
    btn_right = 1;
    frames(3);
    chk("pre_reset_cd", {13'd0, moving}, 14'd1);
    do_reset();
    frames(1);
    chk("after_reset_tick1", entity, 14'h0465);
    frames(1);
    chk("after_reset_tick2", entity, 14'h0575);
    btn_right = 0;

    // Randomised frames
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 3) == 0)
        {btn_left, btn_down, btn_right, btn_up} = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) do_reset();
      frame(1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/player_entity_controller.md
# player_entity_controller

Upstream stage of the frame buffer controller. Turns four raw player buttons into one 14-bit entity descriptor: 4-bit ID, 2-bit orientation, 8-bit tile location. The descriptor drives one entity channel of the frame buffer controller. It moves the entity at most one tile per MOVE_PERIOD frames and changes only during vertical blanking, so a scanned frame never shows a half-updated entity.

## Interface
- ENTITY_ID, 4'h1: constant placed in descriptor bits [13:10].
- START_TILE, 8'h65: location loaded at reset, {x[3:0], y[3:0]}.
- MOVE_PERIOD, 4: frames between moves while a direction is held, range 1..15.
- GRID_ROWS, 12: number of valid y rows; x is always 0..15.

- clk  in  1  pixel clock, same as the VGA timing generator.
- reset  in  1  asynchronous, active-high.
- btn_up / btn_right / btn_down / btn_left  in  1 each  raw, asynchronous, active-high buttons.
- counter_H  in  10  horizontal pixel counter from the VGA timing generator.
- counter_V  in  10  vertical pixel counter from the VGA timing generator.
- entity  out  14  {ENTITY_ID, orient[1:0], x[3:0], y[3:0]}.
- moving  out  1  high while the cooldown is running (state COOLDOWN).

## Operation
- Synchroniser: each button passes through 2 flops before any other use.
- Frame tick: a 1-cycle internal pulse when counter_V==480 and counter_H==0, the first cycle of vblank. Exactly one tick per frame.
- Debounce: synchronised buttons are sampled only on a tick. A direction counts as held when it is high on the current tick and the previous tick.
- Direction priority when several are held: up > right > down > left. Opposite pairs resolve by the same priority.
- Orientation encoding: 00 up, 01 right, 10 down, 11 left.
- Coordinates: up = y-1, down = y+1, left = x-1, right = x+1.
- Edges clamp: y stays within 0..GRID_ROWS-1, x within 0..15.
  - A blocked move still updates the orientation.
  - A blocked move still starts the cooldown.
  - Nothing ever wraps around.
- FSM states:
  - IDLE: on a tick with a held direction, update orient and location, load cooldown = MOVE_PERIOD-1, then go to COOLDOWN. If MOVE_PERIOD==1, stay in IDLE.
  - COOLDOWN: each tick decrements cooldown. When cooldown==0 and a tick arrives:
    - direction held: move and reload the cooldown (auto-repeat).
    - no direction held: go to IDLE.
  - Releasing the buttons during COOLDOWN does not cancel the cooldown.
- Reset values:
  - entity = {ENTITY_ID, 2'b00, START_TILE}.
  - moving = 0.
  - state = IDLE, cooldown = 0, debounce history = 0, synchroniser flops = 0.
- Reset asserted mid-cooldown: all registers return to their reset values immediately (asynchronous). The first move after reset needs two ticks of held input.

## Timing
- entity and moving are registered outputs.
- They change only on the clock edge that follows the tick cycle, so every update lands in vblank line 480.
- Button-to-move latency: 2 synchroniser cycles, plus 2 ticks of debounce, plus 1 cycle.
- Sustained hold: one tile per MOVE_PERIOD frames.
- counter_H / counter_V are sampled combinationally for tick detection only. The tick compare must stay within one cycle of logic.
- No handshake with the frame buffer controller: entity is level data that holds its value between ticks.

## Structure
- Shared package stt8_entity_pkg holds:
  - orientation constants ORIENT_UP/RIGHT/DOWN/LEFT.
  - descriptor field widths: ID 4, ORIENT 2, LOC 8.
  - VBLANK_LINE = 480.
  - the unused-channel ID 4'hF.
- One sub-module, button_sync_debounce: 2-flop synchroniser plus the tick-sampled history bit, instantiated once per button.
- The FSM, cooldown counter and location update live in the top of this block.

## Test plan
- Reset: assert reset mid-frame -> entity = 14'h0465 (ID 1, orient 00, tile 8'h65), moving = 0, asynchronously with no clock edge needed.
- Single right press held for 2 frames, MOVE_PERIOD = 4 -> on the 2nd tick entity becomes 14'h0575 (orient 01, x = 7), moving = 1. Check the change lands on the cycle after counter_V==480 && counter_H==0.
- Hold up for 10 frames from y = 5 -> moves on ticks 2, 6 and 10. y reads 4, 3, 2. The descriptor does not change between those ticks.
- Edge clamp: START_TILE = 8'h0B, hold down -> y stays 11, orient becomes 10, moving asserts. Hold left -> x stays 0, orient becomes 11.
- Priority and glitches:
  - up+down held together -> up wins (orient 00).
  - a 1-tick button pulse -> no move.
  - a button toggling mid-line between ticks -> ignored.
- Reset during COOLDOWN (cooldown = 2) -> state IDLE, moving = 0. After release, the next held direction needs 2 ticks before it moves.
